// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC sequencer: FSM state encoding and default job-length width.
package mac_ctrl_pkg;

  localparam int unsigned LenWDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mac_en_pipe.sv
// Two-stage enable delay line: a load pulse becomes a mult pulse one cycle later and an
// acc pulse two cycles later. A synchronous flush empties both stages.
module mac_en_pipe (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic load_i,
  output logic mult_o,
  output logic acc_o
);

  logic mult_q, mult_d;
  logic acc_q, acc_d;

  always_comb begin
    mult_d = 1'b0;
    acc_d  = 1'b0;
    if (!flush_i) begin
      mult_d = load_i;
      acc_d  = mult_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mult_q <= 1'b0;
      acc_q  <= 1'b0;
    end else begin
      mult_q <= mult_d;
      acc_q  <= acc_d;
    end
  end

  assign mult_o = mult_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for a load/mult/acc MAC: accepts LEN operand pairs over a
// valid/ready handshake, paces the MAC enables and holds the final result until taken.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             mac_clr,
  output logic             mac_load,
  output logic             mac_mult,
  output logic             mac_acc,
  output logic             res_valid,
  input  logic             res_ready
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             clr_q, clr_d;
  logic             rv_q, rv_d;

  logic             abort_hit;
  logic             last_pair;

  assign abort_hit = abort & (state_q != StIdle);
  // Abort must suppress a handshake in the very cycle it is raised.
  assign op_ready  = rdy_q & ~abort_hit;
  assign mac_load  = op_valid & op_ready;
  assign last_pair = (issued_q == len_q - LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = len;
          issued_d = '0;
          state_d  = StClear;
        end
      end
      StClear: begin
        state_d = (len_q == '0) ? StDrain : StRun;
      end
      StRun: begin
        if (mac_load) begin
          issued_d = issued_q + LEN_W'(1);
          if (last_pair) state_d = StDrain;
        end
      end
      StDrain: begin
        // No load is possible here, so once mult is low the pipe is empty after this edge
        // and the accumulator holds the final sum in the next cycle.
        if (!mac_mult) state_d = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_hit) state_d = StIdle;

    busy_d = (state_d != StIdle);
    rdy_d  = (state_d == StRun);
    clr_d  = (state_d == StClear) | abort_hit;
    rv_d   = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      clr_q    <= 1'b1;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      clr_q    <= clr_d;
      rv_q     <= rv_d;
    end
  end

  assign busy      = busy_q;
  assign mac_clr   = clr_q;
  assign res_valid = rv_q;

  mac_en_pipe u_en_pipe (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (abort_hit),
    .load_i  (mac_load),
    .mult_o  (mac_mult),
    .acc_o   (mac_acc)
  );

  a_load_in_run: assert property (@(posedge clk) disable iff (reset)
    mac_load |-> (state_q == StRun));

  a_load_bounded: assert property (@(posedge clk) disable iff (reset)
    mac_load |-> (issued_q < len_q));

  a_result_held: assert property (@(posedge clk) disable iff (reset)
    (res_valid && !res_ready && !abort) |=> res_valid);

endmodule
